// File: rtl/victim_buffer_pkg.sv
// victim_buffer_pkg: shared types and default sizes for the victim buffer
package victim_buffer_pkg;
    typedef logic [11:0] lc3b_vtag;
    typedef enum logic {VB_IDLE, VB_WB} vb_state_t;
    localparam int VB_WIDTH = 128;
    localparam int VB_DEPTH = 16;
    localparam int VB_TAG_W = 12;
endpackage

// File: rtl/victim_buffer_if.sv
// victim_buffer_if: insert, lookup and write-back signals between L1 and the victim buffer
interface victim_buffer_if
    import victim_buffer_pkg::*;
#(
    parameter int WIDTH = VB_WIDTH,
    parameter int DEPTH = VB_DEPTH,
    parameter int TAG_W = VB_TAG_W
);
    logic                     ins_valid;
    logic [TAG_W-1:0]         ins_tag;
    logic [WIDTH-1:0]         ins_data;
    logic                     ins_dirty;
    logic                     ins_ready;
    logic [TAG_W-1:0]         lk_tag;
    logic                     lk_hit;
    logic [WIDTH-1:0]         lk_data;
    logic                     lk_dirty;
    logic                     lk_take;
    logic                     wb_valid;
    logic [TAG_W-1:0]         wb_tag;
    logic [WIDTH-1:0]         wb_data;
    logic                     wb_ready;
    logic [$clog2(DEPTH):0]   count;
    modport master (
        output ins_valid, ins_tag, ins_data, ins_dirty, lk_tag, lk_take, wb_ready,
        input  ins_ready, lk_hit, lk_data, lk_dirty, wb_valid, wb_tag, wb_data, count
    );
    modport slave (
        input  ins_valid, ins_tag, ins_data, ins_dirty, lk_tag, lk_take, wb_ready,
        output ins_ready, lk_hit, lk_data, lk_dirty, wb_valid, wb_tag, wb_data, count
    );
endinterface

// File: rtl/victim_buffer_line_array.sv
// victim_line_array: line data storage, one write port, every line readable in parallel
module victim_line_array #(
    parameter int WIDTH = 128,
    parameter int DEPTH = 16
) (
    input  logic                           clk,
    input  logic                           i_we,
    input  logic [$clog2(DEPTH)-1:0]       i_waddr,
    input  logic [WIDTH-1:0]               i_wdata,
    output logic [DEPTH-1:0][WIDTH-1:0]    o_lines
);
    logic [DEPTH-1:0][WIDTH-1:0] r_mem;
    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end
    assign o_lines = r_mem;
endmodule

// File: rtl/victim_buffer.sv
// victim_buffer: fully-associative victim buffer with round-robin replacement and dirty write-back
module victim_buffer
    import victim_buffer_pkg::*;
#(
    parameter int WIDTH = VB_WIDTH,
    parameter int DEPTH = VB_DEPTH,
    parameter int TAG_W = VB_TAG_W
) (
    input  logic            clk,
    input  logic            rst,
    victim_buffer_if.slave  bus
);
    localparam int IW = $clog2(DEPTH);

    logic [DEPTH-1:0]            r_valid, r_dirty;
    logic [TAG_W-1:0]            r_tag [DEPTH];
    logic [IW-1:0]               r_rr;
    vb_state_t                   r_state;
    logic                        r_ins_ready, r_wb_valid;
    logic [TAG_W-1:0]            r_hold_tag;
    logic [WIDTH-1:0]            r_hold_data;
    logic                        r_hold_dirty;

    logic [DEPTH-1:0][WIDTH-1:0] w_lines;
    logic [DEPTH-1:0]            w_lk_match, w_ins_match, w_vtake, w_valid_n, w_dirty_n;
    logic [IW-1:0]               w_lk_idx, w_dup_idx, w_free_idx, w_widx;
    logic [IW:0]                 w_count;
    logic                        w_lk_hit, w_take, w_dup, w_full, w_accept, w_evict, w_drain;
    logic                        w_we, w_wdirty, w_rr_adv;
    logic [TAG_W-1:0]            w_wtag;
    logic [WIDTH-1:0]            w_wdata;
    vb_state_t                   w_state_n;

    victim_line_array #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_lines (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (w_widx),
        .i_wdata (w_wdata),
        .o_lines (w_lines)
    );

    // Insert-side matching sees the valid bits after any same-cycle take.
    always_comb begin
        w_lk_match  = '0;
        w_ins_match = '0;
        w_lk_idx    = '0;
        w_dup_idx   = '0;
        w_free_idx  = '0;
        w_count     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_lk_match[i] = r_valid[i] && r_tag[i] == bus.lk_tag;
            w_lk_idx      = w_lk_match[i] ? IW'(i) : w_lk_idx;
            w_count       = w_count + (IW+1)'(r_valid[i]);
        end
        w_lk_hit = |w_lk_match;
        w_take   = bus.lk_take && w_lk_hit;
        w_vtake  = w_take ? r_valid & ~w_lk_match : r_valid;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            w_ins_match[i] = w_vtake[i] && r_tag[i] == bus.ins_tag;
            w_dup_idx      = w_ins_match[i] ? IW'(i) : w_dup_idx;
            w_free_idx     = w_vtake[i] ? w_free_idx : IW'(i);
        end
        w_dup  = |w_ins_match;
        w_full = &w_vtake;
    end

    always_comb begin
        w_accept  = r_state == VB_IDLE && bus.ins_valid;
        w_evict   = w_accept && !w_dup && w_full && r_dirty[r_rr];
        w_drain   = r_state == VB_WB && bus.wb_ready;
        w_we      = (w_accept && !w_evict) || w_drain;
        w_widx    = w_drain ? r_rr : w_dup ? w_dup_idx : !w_full ? w_free_idx : r_rr;
        w_wdata   = w_drain ? r_hold_data : bus.ins_data;
        w_wtag    = w_drain ? r_hold_tag : bus.ins_tag;
        w_wdirty  = w_drain ? r_hold_dirty : w_dup ? (r_dirty[w_dup_idx] | bus.ins_dirty) : bus.ins_dirty;
        w_rr_adv  = w_drain || (w_accept && !w_dup && w_full && !r_dirty[r_rr]);
        w_state_n = w_evict ? VB_WB : w_drain ? VB_IDLE : r_state;
        w_valid_n = w_vtake;
        w_dirty_n = r_dirty & w_vtake;
        if (w_we) begin
            w_valid_n[w_widx] = 1'b1;
            w_dirty_n[w_widx] = w_wdirty;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid     <= '0;
            r_dirty     <= '0;
            r_rr        <= '0;
            r_state     <= VB_IDLE;
            r_ins_ready <= 1'b1;
            r_wb_valid  <= 1'b0;
        end else begin
            r_valid     <= w_valid_n;
            r_dirty     <= w_dirty_n;
            r_rr        <= r_rr + IW'(w_rr_adv);
            r_state     <= w_state_n;
            r_ins_ready <= w_state_n == VB_IDLE;
            r_wb_valid  <= w_state_n == VB_WB;
        end
    end

    always_ff @(posedge clk) begin
        if (w_we) r_tag[w_widx] <= w_wtag;
        if (w_evict) begin
            r_hold_tag   <= bus.ins_tag;
            r_hold_data  <= bus.ins_data;
            r_hold_dirty <= bus.ins_dirty;
        end
    end

    assign bus.ins_ready = r_ins_ready;
    assign bus.wb_valid  = r_wb_valid;
    assign bus.wb_tag    = r_tag[r_rr];
    assign bus.wb_data   = w_lines[r_rr];
    assign bus.lk_hit    = w_lk_hit;
    assign bus.lk_data   = w_lk_hit ? w_lines[w_lk_idx] : '0;
    assign bus.lk_dirty  = w_lk_hit && r_dirty[w_lk_idx];
    assign bus.count     = w_count;
endmodule

// File: tb/tb_victim_buffer.sv
// tb_victim_buffer: directed checks of insert, lookup, take, eviction and write-back
module tb_victim_buffer;
    import victim_buffer_pkg::*;

    typedef struct {
        lc3b_vtag     tag;
        logic         hit;
        logic [127:0] data;
        logic         dirty;
    } probe_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;
    probe_t tbl[5];

    victim_buffer_if vb();
    victim_buffer dut (.clk(clk), .rst(rst), .bus(vb));

    always #5 clk = ~clk;

    function automatic logic [127:0] dat(input lc3b_vtag t);
        return {4{20'hC0DE5, t}};
    endfunction

    task automatic chk(input string n, input logic [127:0] a, input logic [127:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", n, a, e);
        end
    endtask

    task automatic idle();
        vb.ins_valid = 1'b0;
        vb.lk_take   = 1'b0;
        vb.wb_ready  = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic look(input lc3b_vtag t);
        vb.lk_tag = t;
        #1;
    endtask

    task automatic ins(input lc3b_vtag t, input logic d, input logic [127:0] x);
        vb.ins_valid = 1'b1;
        vb.ins_tag   = t;
        vb.ins_dirty = d;
        vb.ins_data  = x;
        tick();
        idle();
    endtask

    initial begin
        idle();
        vb.ins_tag   = '0;
        vb.ins_data  = '0;
        vb.ins_dirty = 1'b0;
        vb.lk_tag    = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("rst_count", vb.count, 0);
        chk("rst_ins_ready", vb.ins_ready, 1);
        chk("rst_wb_valid", vb.wb_valid, 0);
        look(12'h005);
        chk("rst_lk_hit", vb.lk_hit, 0);
        chk("rst_lk_data", vb.lk_data, 0);

        for (int t = 1; t <= 16; t++) begin
            #1;
            chk("fill_ins_ready", vb.ins_ready, 1);
            ins(lc3b_vtag'(t), 1'b0, dat(lc3b_vtag'(t)));
        end
        #1;
        chk("fill_count", vb.count, 16);
        tbl[0] = '{12'h005, 1'b1, dat(12'h005), 1'b0};
        tbl[1] = '{12'h001, 1'b1, dat(12'h001), 1'b0};
        tbl[2] = '{12'h010, 1'b1, dat(12'h010), 1'b0};
        tbl[3] = '{12'h011, 1'b0, 128'h0, 1'b0};
        tbl[4] = '{12'h000, 1'b0, 128'h0, 1'b0};
        for (int i = 0; i < 5; i++) begin
            look(tbl[i].tag);
            chk("tbl_hit", vb.lk_hit, tbl[i].hit);
            chk("tbl_data", vb.lk_data, tbl[i].data);
            chk("tbl_dirty", vb.lk_dirty, tbl[i].dirty);
        end

        ins(12'h0AA, 1'b0, dat(12'h0AA));
        chk("clean_repl_wb_valid", vb.wb_valid, 0);
        chk("clean_repl_count", vb.count, 16);
        look(12'h001);
        chk("clean_repl_old_miss", vb.lk_hit, 0);
        look(12'h0AA);
        chk("clean_repl_new_data", vb.lk_data, dat(12'h0AA));
        tick();
        chk("clean_repl_wb_valid2", vb.wb_valid, 0);

        ins(12'h002, 1'b1, dat(12'h002));
        look(12'h002);
        chk("dup_dirty_set", vb.lk_dirty, 1);
        chk("dup_count", vb.count, 16);
        ins(12'h0BB, 1'b0, dat(12'h0BB));
        chk("wb_valid_up", vb.wb_valid, 1);
        chk("wb_ins_ready", vb.ins_ready, 0);
        chk("wb_tag", vb.wb_tag, 12'h002);
        chk("wb_data", vb.wb_data, dat(12'h002));
        look(12'h002);
        chk("wb_drain_still_hit", vb.lk_hit, 1);
        look(12'h0BB);
        chk("wb_held_not_visible", vb.lk_hit, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("wb_stall_valid", vb.wb_valid, 1);
        end
        vb.wb_ready = 1'b1;
        tick();
        idle();
        #1;
        chk("wb_done_valid", vb.wb_valid, 0);
        chk("wb_done_ins_ready", vb.ins_ready, 1);
        look(12'h0BB);
        chk("wb_done_new_data", vb.lk_data, dat(12'h0BB));
        look(12'h002);
        chk("wb_done_old_miss", vb.lk_hit, 0);
        chk("wb_done_count", vb.count, 16);

        vb.lk_tag  = 12'h007;
        vb.lk_take = 1'b1;
        #1;
        chk("take_hit_now", vb.lk_hit, 1);
        tick();
        idle();
        #1;
        chk("take_miss_next", vb.lk_hit, 0);
        chk("take_count", vb.count, 15);

        ins(12'h0DD, 1'b0, dat(12'h0DD));
        chk("refill_count", vb.count, 16);
        vb.lk_tag    = 12'h003;
        vb.lk_take   = 1'b1;
        ins(12'h0CC, 1'b0, dat(12'h0CC));
        chk("take_ins_wb_valid", vb.wb_valid, 0);
        chk("take_ins_count", vb.count, 16);
        look(12'h0CC);
        chk("take_ins_new_hit", vb.lk_hit, 1);
        look(12'h003);
        chk("take_ins_old_miss", vb.lk_hit, 0);
        ins(12'h0EE, 1'b0, dat(12'h0EE));
        look(12'h0CC);
        chk("rr_unchanged_cc_evicted", vb.lk_hit, 0);
        look(12'h0EE);
        chk("rr_unchanged_ee_hit", vb.lk_hit, 1);
        look(12'h004);
        chk("rr_unchanged_004_kept", vb.lk_hit, 1);

        ins(12'h0AA, 1'b1, dat(12'h0AA));
        vb.lk_tag  = 12'h0AA;
        vb.lk_take = 1'b1;
        ins(12'h0AA, 1'b0, ~dat(12'h0AA));
        look(12'h0AA);
        chk("fresh_hit", vb.lk_hit, 1);
        chk("fresh_dirty", vb.lk_dirty, 0);
        chk("fresh_data", vb.lk_data, ~dat(12'h0AA));
        chk("fresh_count", vb.count, 16);

        ins(12'h004, 1'b1, dat(12'h004));
        ins(12'h004, 1'b0, ~dat(12'h004));
        look(12'h004);
        chk("dup_clean_data", vb.lk_data, ~dat(12'h004));
        chk("dup_clean_dirty", vb.lk_dirty, 1);
        chk("dup_clean_count", vb.count, 16);
        ins(12'h0FF, 1'b0, dat(12'h0FF));
        chk("wb2_valid", vb.wb_valid, 1);
        chk("wb2_tag", vb.wb_tag, 12'h004);
        chk("wb2_data", vb.wb_data, ~dat(12'h004));
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("rst_wb_valid_drop", vb.wb_valid, 0);
        chk("rst_wb_count", vb.count, 0);
        chk("rst_wb_ins_ready", vb.ins_ready, 1);
        look(12'h004);
        chk("rst_wb_miss", vb.lk_hit, 0);
        ins(12'h123, 1'b0, dat(12'h123));
        look(12'h123);
        chk("post_rst_hit", vb.lk_data, dat(12'h123));
        chk("post_rst_count", vb.count, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
